// File: rtl/aftab_mul_sequencer.sv
// Sequencer in front of a multi-cycle Booth multiplier: operand extension per
// RISC-V M op, launch/wait handshake, and a one-entry product cache.
module aftab_mul_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic              mul_start,
  output logic [XLEN:0]     mul_M,
  output logic [XLEN:0]     mul_Q,
  input  logic              mul_done,
  input  logic [2*XLEN+1:0] mul_P,
  output logic [XLEN-1:0]   result,
  output logic              result_valid
);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic                sign1_q;
  logic                sign2_q;

  logic                c_valid;
  logic [XLEN-1:0]     c_rs1;
  logic [XLEN-1:0]     c_rs2;
  logic                c_sign1;
  logic                c_sign2;
  logic [2*XLEN-1:0]   c_prod;

  logic                sign1;
  logic                sign2;
  logic                accept;
  logic                tag_match;
  logic                hit;

  // Bits above 2*XLEN-1 of the Booth product carry only sign extension.
  logic                unused_p_hi;
  assign unused_p_hi = ^mul_P[2*XLEN+1:2*XLEN];

  assign sign1     = (op != OP_MULHU);
  assign sign2     = ~op[1];
  assign accept    = req_valid && req_ready && (state == S_IDLE);
  assign tag_match = c_valid && (rs1 == c_rs1) && (rs2 == c_rs2);
  // The low word is independent of operand signedness, so MUL ignores sign tags.
  assign hit       = tag_match &&
                     ((op == OP_MUL) || ((sign1 == c_sign1) && (sign2 == c_sign2)));

  function automatic logic [XLEN-1:0] pick_word(input logic [1:0] sel,
                                                input logic [2*XLEN-1:0] prod);
    if (sel == OP_MUL) return prod[XLEN-1:0];
    else               return prod[2*XLEN-1:XLEN];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      req_ready    <= 1'b0;
      mul_start    <= 1'b0;
      mul_M        <= '0;
      mul_Q        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      op_q         <= '0;
      sign1_q      <= 1'b0;
      sign2_q      <= 1'b0;
      c_valid      <= 1'b0;
      c_rs1        <= '0;
      c_rs2        <= '0;
      c_sign1      <= 1'b0;
      c_sign2      <= 1'b0;
      c_prod       <= '0;
    end else begin
      mul_start    <= 1'b0;
      result_valid <= 1'b0;
      req_ready    <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            op_q      <= op;
            sign1_q   <= sign1;
            sign2_q   <= sign2;
            mul_M     <= {sign1 & rs1[XLEN-1], rs1};
            mul_Q     <= {sign2 & rs2[XLEN-1], rs2};
            if (hit) begin
              result       <= pick_word(op, c_prod);
              result_valid <= 1'b1;
              state        <= S_DONE;
            end else begin
              mul_start <= 1'b1;
              state     <= S_LAUNCH;
            end
          end
        end
        // A done flag seen while launching belongs to no request of ours.
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (mul_done) begin
            c_valid      <= 1'b1;
            c_rs1        <= mul_M[XLEN-1:0];
            c_rs2        <= mul_Q[XLEN-1:0];
            c_sign1      <= sign1_q;
            c_sign2      <= sign2_q;
            c_prod       <= mul_P[2*XLEN-1:0];
            result       <= pick_word(op_q, mul_P[2*XLEN-1:0]);
            result_valid <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aftab_mul_sequencer.sv
// Randomized bench for aftab_mul_sequencer with a behavioural Booth stand-in
// and an arithmetic reference for products and cache hit prediction.
module tb_aftab_mul_sequencer;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        mul_start;
  logic [32:0] mul_M;
  logic [32:0] mul_Q;
  logic        mul_done;
  logic [65:0] mul_P;
  logic [31:0] result;
  logic        result_valid;

  aftab_mul_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .mul_start(mul_start),
    .mul_M(mul_M), .mul_Q(mul_Q), .mul_done(mul_done), .mul_P(mul_P),
    .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Booth multiplier stand-in
  int          booth_starts = 0;
  int          booth_cnt    = 0;
  int          booth_lat    = 0;
  bit          booth_busy   = 0;
  bit          booth_hold   = 0;
  bit          glitch_en    = 0;
  logic [65:0] booth_prod;

  function automatic logic [65:0] booth_mul(input logic [32:0] m, input logic [32:0] q);
    logic signed [65:0] a, b;
    a = {{33{m[32]}}, m};
    b = {{33{q[32]}}, q};
    return a * b;
  endfunction

  initial begin
    mul_done = 1'b0;
    mul_P    = '0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (booth_busy && !booth_hold) begin
        if (booth_cnt == 0) begin
          mul_done   = 1'b1;
          mul_P      = booth_prod;
          booth_busy = 0;
        end else begin
          booth_cnt--;
        end
      end
      if (mul_start) begin
        booth_starts++;
        booth_busy = 1;
        booth_cnt  = $urandom_range(0, 3);
        booth_lat  = booth_cnt;
        booth_prod = booth_mul(mul_M, mul_Q);
        if (glitch_en) begin
          mul_done = 1'b1;
          mul_P    = ~booth_prod;
        end
      end
    end
  end

  // Reference: product from plain signed arithmetic, one-entry cache model
  bit          mc_valid = 0;
  logic [31:0] mc_rs1, mc_rs2;
  bit          mc_s1, mc_s2;

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [65:0] x, y, p;
    x = (o != 2'b11) ? {{34{a[31]}}, a} : {34'd0, a};
    y = (o < 2'd2)   ? {{34{b[31]}}, b} : {34'd0, b};
    p = x * y;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic do_req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_other);
    int          lat, starts0, n;
    bit          s1, s2, exp_hit;
    logic [32:0] em, eq;
    logic [31:0] er;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", req_ready, 1'b1);
    s1 = (o != 2'b11);
    s2 = (o < 2'd2);
    exp_hit = mc_valid && a == mc_rs1 && b == mc_rs2 &&
              (o == 2'b00 || (s1 == mc_s1 && s2 == mc_s2));
    em = {s1 & a[31], a};
    eq = {s2 & b[31], b};
    er = ref_result(o, a, b);
    starts0 = booth_starts;
    req_valid = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    req_valid = 1'b0;
    check("mul_M", mul_M, em);
    check("mul_Q", mul_Q, eq);
    check("ready_busy", req_ready, 1'b0);
    if (hold_other) begin
      req_valid = 1'b1; op = ~o; rs1 = ~a; rs2 = b ^ 32'h5;
    end
    lat = 1;
    while (!result_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    check("result_valid", result_valid, 1'b1);
    check("result", result, er);
    check("start_count", booth_starts - starts0, exp_hit ? 0 : 1);
    check("latency", lat, exp_hit ? 1 : 3 + booth_lat);
    check("mul_M_held", mul_M, em);
    check("mul_Q_held", mul_Q, eq);
    if (!exp_hit) begin
      mc_valid = 1; mc_rs1 = a; mc_rs2 = b; mc_s1 = s1; mc_s2 = s2;
    end
    @(negedge clk);
    check("rv_pulse", result_valid, 1'b0);
    check("result_hold", result, er);
    check("ready_idle", req_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s0;
    bit          saw_rv;
    logic [31:0] pa, pb, a, b;
    logic [1:0]  o;

    rst = 1'b1; req_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_start", mul_start, 1'b0);
    check("rst_M", mul_M, 33'd0);
    check("rst_Q", mul_Q, 33'd0);
    check("rst_result", result, 32'd0);
    check("rst_rv", result_valid, 1'b0);
    rst = 1'b0;

    // Directed scenarios
    s0 = booth_starts;
    do_req(2'b00, 32'd50, 32'hFFFFFFFD, 0);
    check("mul_first_miss", booth_starts - s0, 1);
    check("mul_value", result, 32'hFFFFFF6A);
    check("mul_M_const", mul_M, 33'h0_00000032);
    check("mul_Q_const", mul_Q, 33'h1_FFFFFFFD);
    s0 = booth_starts;
    do_req(2'b01, 32'd50, 32'hFFFFFFFD, 0);
    check("mulh_hit", booth_starts - s0, 0);
    check("mulh_value", result, 32'hFFFFFFFF);
    s0 = booth_starts;
    do_req(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("mulhu_miss", booth_starts - s0, 1);
    check("mulhu_value", result, 32'hFFFFFFFE);
    s0 = booth_starts;
    do_req(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("mul_after_mulhu_hit", booth_starts - s0, 0);
    check("mul_after_mulhu_value", result, 32'h00000001);
    do_req(2'b10, 32'hFFFFFFFF, 32'd2, 0);
    check("mulhsu_Q_top", mul_Q[32], 1'b0);
    check("mulhsu_value", result, 32'hFFFFFFFF);
    s0 = booth_starts;
    do_req(2'b11, 32'hFFFFFFFF, 32'd2, 0);
    check("mulhu_sign_tag_miss", booth_starts - s0, 1);

    // Done flag raised during LAUNCH must be ignored
    glitch_en = 1;
    do_req(2'b01, 32'h12345678, 32'h9ABCDEF0, 0);
    glitch_en = 0;

    // Reset in the middle of WAIT, then a late done
    booth_hold = 1;
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; op = 2'b00; rs1 = 32'd7; rs2 = 32'd9;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midwait_rst_start", mul_start, 1'b0);
    check("midwait_rst_M", mul_M, 33'd0);
    check("midwait_rst_Q", mul_Q, 33'd0);
    check("midwait_rst_result", result, 32'd0);
    check("midwait_rst_rv", result_valid, 1'b0);
    mc_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    booth_hold = 0;
    saw_rv = 0;
    repeat (6) begin
      @(negedge clk);
      saw_rv |= result_valid;
    end
    check("late_done_ignored", saw_rv, 1'b0);
    s0 = booth_starts;
    do_req(2'b00, 32'd7, 32'd9, 0);
    check("post_rst_miss", booth_starts - s0, 1);

    // Request held during WAIT is ignored until IDLE
    s0 = booth_starts;
    do_req(2'b10, 32'hCAFEF00D, 32'h00001234, 1);
    check("held_req_one_start", booth_starts - s0, 1);
    do_req(2'b01, 32'h35010FF2, 32'h00001231, 0);

    // Random traffic with frequent operand reuse
    pa = 32'd3; pb = 32'd5;
    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        a = pa; b = pb;
      end else begin
        case ($urandom_range(0, 4))
          0: a = 32'h0;
          1: a = 32'hFFFFFFFF;
          2: a = 32'h80000000;
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 4))
          0: b = 32'h0;
          1: b = 32'hFFFFFFFF;
          2: b = 32'h80000000;
          default: b = $urandom;
        endcase
      end
      do_req(o, a, b, $urandom_range(0, 7) == 0);
      pa = a; pb = b;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
